// File: rtl/ahblite_slave_mux_np.sv
// AHB-Lite slave-side response multiplexer with a built-in default slave.
// Registers the address-phase slave select and routes HREADYOUT/HRESP/HRDATA
// from the data-phase slave. Zero or multi-hot selects get a two-cycle ERROR.
// Optional wait-state watchdog: define AHB_MUX_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no data phase in progress, OKAY/ready response
// SLAVE  | data phase owned by the port flagged in sel_q
// ERR1   | default-slave ERROR, first (wait) cycle
// ERR2   | default-slave ERROR, second (completing) cycle
module ahblite_slave_mux_np #(
  parameter int NPORTS         = 8,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HREADY,
  input  logic [1:0]           HTRANS,
  input  logic [NPORTS-1:0]    HSEL,
  input  logic [NPORTS-1:0]    P_HREADYOUT,
  input  logic [NPORTS-1:0]    P_HRESP,
  input  logic [NPORTS*DW-1:0] P_HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [DW-1:0]        HRDATA,
  output logic                 TIMEOUT_IRQ
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SLAVE = 2'd1;
  localparam logic [1:0] ST_ERR1  = 2'd2;
  localparam logic [1:0] ST_ERR2  = 2'd3;

  localparam logic [NPORTS-1:0] ONE = NPORTS'(1);

  logic [1:0]        state_q, state_d;
  logic [NPORTS-1:0] sel_q, sel_d;
  logic              hsel_onehot;
  logic              mux_ready;
  logic              mux_resp;
  logic [DW-1:0]     mux_data;

  // HTRANS[0] only distinguishes NONSEQ/SEQ and IDLE/BUSY, which we treat alike
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  assign hsel_onehot = (HSEL != '0) && ((HSEL & (HSEL - ONE)) == '0);

  // AND-OR mux of the data-phase port; sel_q is one-hot or zero
  always_comb begin
    mux_ready = 1'b0;
    mux_resp  = 1'b0;
    mux_data  = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (sel_q[k]) begin
        mux_ready = mux_ready | P_HREADYOUT[k];
        mux_resp  = mux_resp  | P_HRESP[k];
        mux_data  = mux_data  | P_HRDATA[k*DW +: DW];
      end
    end
  end

`ifdef AHB_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] WCNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          irq_q, irq_d;

  // Next state: address capture on HREADY, plus watchdog abort of a hung slave
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wcnt_d  = wcnt_q;
    irq_d   = 1'b0;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (HREADY) begin
      if (!HTRANS[1]) begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end else if (hsel_onehot) begin
        state_d = ST_SLAVE;
        sel_d   = HSEL;
        wcnt_d  = '0;
      end else begin
        state_d = ST_ERR1;
        sel_d   = '0;
      end
    end
    // watchdog runs even with HREADY low, since the stalled slave holds it low
    if (state_q == ST_SLAVE && !mux_ready) begin
      if (wcnt_q == WCNT_LAST) begin
        state_d = ST_ERR1;
        sel_d   = '0;
        irq_d   = 1'b1;
      end else begin
        wcnt_d = wcnt_q + CW'(1);
      end
    end
  end

  // State, select, wait counter and IRQ registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      wcnt_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wcnt_q  <= wcnt_d;
      irq_q   <= irq_d;
    end
  end

  assign TIMEOUT_IRQ = irq_q;
`else
  // timeout limit has no effect without the watchdog
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES < 2);

  // Next state: address capture on HREADY only; a stalled slave waits forever
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (HREADY) begin
      if (!HTRANS[1]) begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end else if (hsel_onehot) begin
        state_d = ST_SLAVE;
        sel_d   = HSEL;
      end else begin
        state_d = ST_ERR1;
        sel_d   = '0;
      end
    end
  end

  // State and select registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  assign TIMEOUT_IRQ = 1'b0;
`endif

  // Response outputs decoded straight from state, zero latency
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (state_q)
      ST_SLAVE: begin
        HREADYOUT = mux_ready;
        HRESP     = mux_resp;
        HRDATA    = mux_data;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
